// File: rtl/writeptr_full.sv
// writeptr_full: write-domain pointer and full-flag generator for the
// dual-clock FIFO. Holds the binary write address and the Gray write pointer.
// Compares the pointer against the read pointer after it has been
// synchronised into wclk, and produces registered full and sticky overflow
// flags.
// Optional build macro WPTR_LEVEL_EN adds the fill level (wlevel) and the
// almost-full flag (walmost_full). Without the macro both outputs are tied
// to 0.
module writeptr_full #(
   parameter int ADDRSIZE     = 4,
   parameter int AFULL_THRESH = 2
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                woverflow
);

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wgraynext;
   logic              wen;
   logic              wfull_val;

   assign wen       = winc & ~wfull;
   assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
   assign wgraynext = (wbinnext >> 1) ^ wbinnext;
   assign waddr     = wbin[ADDRSIZE-1:0];

   // The FIFO is full when the write pointer is one lap ahead of the read
   // pointer. In Gray code, one lap ahead means the top two bits are
   // inverted and the remaining bits are equal.
   assign wfull_val = (wgraynext ==
                       {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

   // Pointer, full and sticky overflow registers. A write while full is
   // dropped, so the pointers hold their values.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin      <= '0;
         wptr      <= '0;
         wfull     <= 1'b0;
         woverflow <= 1'b0;
      end else begin
         wbin      <= wbinnext;
         wptr      <= wgraynext;
         wfull     <= wfull_val;
         woverflow <= woverflow | (winc & wfull);
      end
   end

`ifdef WPTR_LEVEL_EN
   localparam int                DEPTH     = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(DEPTH - AFULL_THRESH);

   logic [ADDRSIZE:0] rbin_s;
   logic [ADDRSIZE:0] wdiff;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
   // above its position.
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i <= ADDRSIZE; i++) begin
         rbin_s[i] = ^(wq2_rptr >> i);
      end
   end

   assign wdiff = wbinnext - rbin_s;

   // Level and almost-full registers. They use the same timing as wfull.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wlevel       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wlevel       <= wdiff;
         walmost_full <= (wdiff >= AFULL_LVL);
      end
   end
`else
   assign wlevel       = '0;
   assign walmost_full = 1'b0;
`endif

endmodule

// File: doc/writeptr_full.md
# writeptr_full

Write-side pointer and full-flag generator for the dual-clock FIFO, living entirely in the write clock domain. It keeps the binary write address and the Gray-coded write pointer, and compares the pointer against the read pointer after it has been synchronised into the write domain. From that comparison it produces a registered full flag and a sticky overflow flag. It is the write-end counterpart of the read-pointer/empty logic and drives the memory write address and the Gray pointer sent to the read-domain synchroniser.

## Interface
- ADDRSIZE, 4: address width. FIFO depth is DEPTH = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits wide.
- AFULL_THRESH, 2: almost-full margin. Legal range 1..DEPTH-1.
- wclk  in  1  write-domain clock; all state updates on its rising edge.
- wrst  in  1  synchronous, active-high reset.
- winc  in  1  write request for this cycle.
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronised into wclk (two-flop synchroniser outside this block).
- waddr  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0], combinational from the register.
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wlevel  out  ADDRSIZE+1  registered fill level as seen from the write domain, range 0..DEPTH.
- woverflow  out  1  sticky flag: a write was attempted while full.

## Operation
- Accepted write: wen = winc & ~wfull. The memory is written at waddr in the same cycle.
- Binary next value: wbinnext = wbin + wen, modulo 2^(ADDRSIZE+1). The wrap is natural and needs no special case.
- Gray next value: wgraynext = (wbinnext >> 1) ^ wbinnext.
- On each edge: {wbin, wptr} <= {wbinnext, wgraynext}.
- Full detection: wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). wfull <= wfull_val.
- Level: rbin_s = Gray-to-binary of wq2_rptr. wlevel <= wbinnext - rbin_s, modulo 2^(ADDRSIZE+1).
- Almost-full: walmost_full <= (wbinnext - rbin_s) >= DEPTH - AFULL_THRESH.
- Overflow: woverflow <= woverflow | (winc & wfull). It is cleared only by wrst.
- Full is pessimistic by design. It stays asserted until the read pointer arrives through the synchroniser, so the block can never overwrite unread data.
- A write while full is dropped: wbin, wptr and waddr hold their values.
- Reset values: wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
- wrst has priority over winc in the same cycle.
- Reset mid-operation returns every output to its reset value at the next edge. Read-side reset must be coordinated at system level; it is not handled here.

## Timing
- waddr is valid in the cycle the write is issued. wptr and waddr advance at the edge that accepts the write.
- wfull rises at the edge that accepts the DEPTH-th outstanding write, so there is zero bubble. The next winc in the following cycle is already blocked.
- wfull falls one wclk after wq2_rptr changes. Counted from the actual read, the release is 3 wclk later, including the external 2-flop synchroniser.
- wlevel and walmost_full use the same registered timing as wfull, computed from wbinnext.
- If a write and a wq2_rptr change happen in the same cycle, both are reflected in one update.

## Configuration
- Macro WPTR_LEVEL_EN.
- Defined: the Gray-to-binary decoder, the subtractor, wlevel and walmost_full are built as described above.
- Undefined: wlevel is tied to 0, walmost_full is tied to 0, and the decoder and subtractor are not synthesised.
- wfull and woverflow behave identically with or without the macro.

## Test plan
- Reset: hold wrst=1 with winc=1 for 2 cycles. Required: all outputs 0 and waddr=0. After release with winc=0, outputs stay 0.
- Fill (ADDRSIZE=4, wq2_rptr=0): 16 back-to-back writes. Required: waddr steps 0..15, wptr follows the Gray sequence, wfull=1 after the 16th edge, and wptr=5'b11000.
- Overflow: with the FIFO full as above, assert winc for 2 cycles. Required: wptr stays 5'b11000, waddr stays 0, woverflow=1 and stays 1 after winc drops; only wrst clears it.
- Release and refill: from full, set wq2_rptr=5'b00001. Required: wfull=0 one edge later. Then 1 write gives wptr=5'b11001 and wfull=1 again.
- Wrap: wq2_rptr tracks wptr with a 3-cycle lag while 40 writes are issued. Required: waddr wraps 15→0 twice, wptr MSB toggles at binary counts 16 and 32, wfull never asserts.
- Level (WPTR_LEVEL_EN defined, AFULL_THRESH=2, wq2_rptr=0): 14 writes. Required: wlevel=14 and walmost_full=1 after the 14th edge; wlevel=16 after 16 writes. With the macro undefined, both wlevel and walmost_full stay 0 throughout.
